// File: rtl/mvu_8sx8u_dsp48_core_pkg.sv
// rtl/mvu_8sx8u_dsp48_core_pkg.sv - shared constants for the MVU DSP48 compute core
package mvu_8sx8u_dsp48_core_pkg;

  // Enabled edges from sampling a last beat to the result appearing on p
  localparam int PIPELINE_LATENCY = 3;

  // DSP48E2 datapath widths: A port, B port, multiplier output, P/cascade
  localparam int DSP_A_WIDTH = 27;
  localparam int DSP_B_WIDTH = 18;
  localparam int DSP_M_WIDTH = 45;
  localparam int DSP_P_WIDTH = 48;

endpackage

// File: rtl/mvu_8sx8u_dsp48_core_dot_lane.sv
// rtl/mvu_8sx8u_dsp48_core_dot_lane.sv - single-PE SIMD dot product with group accumulator
module mvu_dot_lane
  import mvu_8sx8u_dsp48_core_pkg::*;
#(
  parameter int SIMD               = 1,
  parameter int ACTIVATION_WIDTH   = 8,
  parameter int WEIGHT_WIDTH       = 8,
  parameter int ACCU_WIDTH         = 16,
  parameter int SIGNED_ACTIVATIONS = 0,
  parameter int FORCE_BEHAVIORAL   = 0
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       en,
  input  logic                                       last,
  input  logic                                       zero,
  input  logic [SIMD-1:0][WEIGHT_WIDTH-1:0]          w,
  input  logic [SIMD-1:0][ACTIVATION_WIDTH-1:0]      a,
  output logic                                       vld,
  output logic [ACCU_WIDTH-1:0]                      p
);

  // Activations are carried with one extra bit so unsigned values multiply as signed
  function automatic logic signed [ACTIVATION_WIDTH:0] ext_a(input logic [ACTIVATION_WIDTH-1:0] x);
    return {(SIGNED_ACTIVATIONS != 0) ? x[ACTIVATION_WIDTH-1] : 1'b0, x};
  endfunction

  // DSP-shaped sum: 27x18 signed multiplies chained through a 48-bit cascade (ACCU_WIDTH <= 48)
  function automatic logic [ACCU_WIDTH-1:0] dsp_dot(
    input logic [SIMD-1:0][WEIGHT_WIDTH-1:0]     wv,
    input logic [SIMD-1:0][ACTIVATION_WIDTH-1:0] av
  );
    logic signed [DSP_P_WIDTH-1:0] pc;
    pc = '0;
    for (int s = 0; s < SIMD; s++) begin
      pc = pc + DSP_P_WIDTH'(DSP_M_WIDTH'(DSP_A_WIDTH'(ext_a(av[s]))) *
                             DSP_M_WIDTH'(DSP_B_WIDTH'($signed(wv[s]))));
    end
    return ACCU_WIDTH'(pc);
  endfunction

  // Inferred sum: operands widened to ACCU_WIDTH, wrap-around is modulo 2^ACCU_WIDTH anyway
  function automatic logic [ACCU_WIDTH-1:0] beh_dot(
    input logic [SIMD-1:0][WEIGHT_WIDTH-1:0]     wv,
    input logic [SIMD-1:0][ACTIVATION_WIDTH-1:0] av
  );
    logic [ACCU_WIDTH-1:0] sum;
    sum = '0;
    for (int s = 0; s < SIMD; s++) begin
      sum = sum + ACCU_WIDTH'(ACCU_WIDTH'(ext_a(av[s])) * ACCU_WIDTH'($signed(wv[s])));
    end
    return sum;
  endfunction

  logic [SIMD-1:0][WEIGHT_WIDTH-1:0]     w_q;
  logic [SIMD-1:0][ACTIVATION_WIDTH-1:0] a_q;
  logic                                  v1, l1;
  logic [ACCU_WIDTH-1:0]                 dot;
  logic [ACCU_WIDTH-1:0]                 dot_q;
  logic                                  v2, l2;
  logic [ACCU_WIDTH-1:0]                 acc;

  // Stage 1: register operands; a bubble becomes an invalid beat and drops its last flag
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
      a_q <= '0;
      v1  <= 1'b0;
      l1  <= 1'b0;
    end else if (en) begin
      w_q <= w;
      a_q <= a;
      v1  <= !zero;
      l1  <= last && !zero;
    end
  end

  generate
    if (FORCE_BEHAVIORAL != 0) begin : g_beh
      // Plain inferred multiply-add tree
      always_comb dot = beh_dot(w_q, a_q);
    end else begin : g_dsp
      // Multiply-add shaped to map onto a DSP48E2 cascade
      always_comb dot = dsp_dot(w_q, a_q);
    end
  endgenerate

  // Stage 2: register the SIMD sum with its beat flags
  always_ff @(posedge clk) begin
    if (rst) begin
      dot_q <= '0;
      v2    <= 1'b0;
      l2    <= 1'b0;
    end else if (en) begin
      dot_q <= dot;
      v2    <= v1;
      l2    <= l1;
    end
  end

  // Stage 3: accumulate; a last beat publishes the total and restarts the group at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      p   <= '0;
      vld <= 1'b0;
    end else if (en) begin
      vld <= v2 && l2;
      if (v2) begin
        if (l2) begin
          p   <= acc + dot_q;
          acc <= '0;
        end else begin
          acc <= acc + dot_q;
        end
      end
    end
  end

endmodule

// File: rtl/mvu_8sx8u_dsp48_core.sv
// rtl/mvu_8sx8u_dsp48_core.sv - MVU compute core: PE parallel dot-product lanes sharing one activation vector
module mvu_8sx8u_dsp48_core #(
  parameter int PE                 = 1,
  parameter int SIMD               = 1,
  parameter int ACTIVATION_WIDTH   = 8,
  parameter int WEIGHT_WIDTH       = 8,
  parameter int ACCU_WIDTH         = 16,
  parameter int SIGNED_ACTIVATIONS = 0,
  parameter int FORCE_BEHAVIORAL   = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               last,
  input  logic                               zero,
  input  logic [PE*SIMD*WEIGHT_WIDTH-1:0]    w,
  input  logic [SIMD*ACTIVATION_WIDTH-1:0]   a,
  output logic                               vld,
  output logic [PE*ACCU_WIDTH-1:0]           p
);

  typedef logic [PE-1:0][SIMD-1:0][WEIGHT_WIDTH-1:0] w_arr_t;
  typedef logic [SIMD-1:0][ACTIVATION_WIDTH-1:0]     a_arr_t;
  typedef logic [PE-1:0][ACCU_WIDTH-1:0]             p_arr_t;

  w_arr_t        w_arr;
  a_arr_t        a_arr;
  p_arr_t        p_arr;
  logic [PE-1:0] vld_lane;

  assign w_arr = w;
  assign a_arr = a;
  assign p     = p_arr;
  // Every lane sees the same control, so all lanes complete together
  assign vld   = &vld_lane;

  for (genvar g = 0; g < PE; g++) begin : g_pe
    mvu_dot_lane #(
      .SIMD               (SIMD),
      .ACTIVATION_WIDTH   (ACTIVATION_WIDTH),
      .WEIGHT_WIDTH       (WEIGHT_WIDTH),
      .ACCU_WIDTH         (ACCU_WIDTH),
      .SIGNED_ACTIVATIONS (SIGNED_ACTIVATIONS),
      .FORCE_BEHAVIORAL   (FORCE_BEHAVIORAL)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .last (last),
      .zero (zero),
      .w    (w_arr[g]),
      .a    (a_arr),
      .vld  (vld_lane[g]),
      .p    (p_arr[g])
    );
  end

endmodule

// File: tb/tb_mvu_8sx8u_dsp48_core.sv
// tb/tb_mvu_8sx8u_dsp48_core.sv - self-checking bench for the MVU compute core
module tb_mvu_8sx8u_dsp48_core;
  import mvu_8sx8u_dsp48_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, last, zero;
  logic [63:0] w;
  logic [31:0] a;
  logic        vld_u, vld_s;
  logic [31:0] p_u;
  logic [39:0] p_s;

  always #5 clk = ~clk;

  mvu_8sx8u_dsp48_core #(
    .PE(2), .SIMD(4), .ACTIVATION_WIDTH(8), .WEIGHT_WIDTH(8),
    .ACCU_WIDTH(16), .SIGNED_ACTIVATIONS(0), .FORCE_BEHAVIORAL(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .last(last), .zero(zero),
    .w(w), .a(a), .vld(vld_u), .p(p_u)
  );

  mvu_8sx8u_dsp48_core #(
    .PE(2), .SIMD(4), .ACTIVATION_WIDTH(8), .WEIGHT_WIDTH(8),
    .ACCU_WIDTH(20), .SIGNED_ACTIVATIONS(1), .FORCE_BEHAVIORAL(1)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en), .last(last), .zero(zero),
    .w(w), .a(a), .vld(vld_s), .p(p_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: exact integer group sums, each result due a fixed number of enabled edges later
  typedef struct {
    int     due;
    longint ru0, ru1, rs0, rs1;
  } res_t;

  res_t   q[$];
  longint acc_u[2], acc_s[2];
  longint exp_u[2], exp_s[2];
  logic   exp_vld;
  int     edge_n;

  function automatic longint dot(input int pe, input bit sgn);
    longint sum = 0;
    for (int s = 0; s < 4; s++) begin
      longint wv, av;
      wv = longint'($signed(w[(pe*4+s)*8 +: 8]));
      av = sgn ? longint'($signed(a[s*8 +: 8])) : longint'(a[s*8 +: 8]);
      sum += wv * av;
    end
    return sum;
  endfunction

  task automatic model_step();
    res_t r;
    if (rst) begin
      q.delete();
      for (int i = 0; i < 2; i++) begin
        acc_u[i] = 0; acc_s[i] = 0; exp_u[i] = 0; exp_s[i] = 0;
      end
      exp_vld = 1'b0;
    end else if (en) begin
      edge_n++;
      exp_vld = 1'b0;
      if (q.size() > 0 && q[0].due == edge_n) begin
        exp_vld  = 1'b1;
        exp_u[0] = q[0].ru0; exp_u[1] = q[0].ru1;
        exp_s[0] = q[0].rs0; exp_s[1] = q[0].rs1;
        void'(q.pop_front());
      end
      if (!zero) begin
        for (int i = 0; i < 2; i++) begin
          acc_u[i] += dot(i, 1'b0);
          acc_s[i] += dot(i, 1'b1);
        end
        if (last) begin
          r.due = edge_n + PIPELINE_LATENCY - 1;
          r.ru0 = acc_u[0]; r.ru1 = acc_u[1];
          r.rs0 = acc_s[0]; r.rs1 = acc_s[1];
          q.push_back(r);
          for (int i = 0; i < 2; i++) begin
            acc_u[i] = 0; acc_s[i] = 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic compare();
    check("vld_u", 64'(vld_u), 64'(exp_vld));
    check("vld_s", 64'(vld_s), 64'(exp_vld));
    check("p_u0", 64'(p_u[15:0]),  64'(exp_u[0]) & 64'hFFFF);
    check("p_u1", 64'(p_u[31:16]), 64'(exp_u[1]) & 64'hFFFF);
    check("p_s0", 64'(p_s[19:0]),  64'(exp_s[0]) & 64'hFFFFF);
    check("p_s1", 64'(p_s[39:20]), 64'(exp_s[1]) & 64'hFFFFF);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic beat(input logic [7:0] w0, input logic [7:0] w1, input logic [31:0] av,
                      input logic l, input logic z);
    w    = {{4{w1}}, {4{w0}}};
    a    = av;
    last = l;
    zero = z;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      beat(8'h00, 8'h00, 32'h0, 1'b0, 1'b1);
      tick();
    end
  endtask

  initial begin
    edge_n = 0; exp_vld = 1'b0;
    for (int i = 0; i < 2; i++) begin
      acc_u[i] = 0; acc_s[i] = 0; exp_u[i] = 0; exp_s[i] = 0;
    end
    rst = 1'b1; en = 1'b1;
    beat(8'h00, 8'h00, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    tick(); tick();
    check("reset_vld", 64'(vld_u), 64'd0);
    check("reset_p", 64'(p_u), 64'd0);
    rst = 1'b0;

    // One-beat group: w0 = 1, w1 = -1, a = [1,2,3,4]
    beat(8'h01, 8'hFF, 32'h04030201, 1'b1, 1'b0);
    tick();
    bubbles(1);
    check("t1_vld_early", 64'(vld_u), 64'd0);
    bubbles(1);
    check("t1_vld", 64'(vld_u), 64'd1);
    check("t1_p0", 64'(p_u[15:0]), 64'd10);
    check("t1_p1", 64'(p_u[31:16]), 64'hFFF6);
    check("t1_s1", 64'(p_s[39:20]), 64'hFFFF6);
    check("t1_model", 64'(exp_u[0]), 64'd10);
    bubbles(1);
    check("t1_vld_drop", 64'(vld_u), 64'd0);
    check("t1_p_hold", 64'(p_u[15:0]), 64'd10);

    // Three beats of 255 * 127, wraps modulo 2^16
    for (int i = 0; i < 3; i++) begin
      beat(8'd127, 8'd127, 32'hFFFFFFFF, (i == 2), 1'b0);
      tick();
    end
    bubbles(2);
    check("t2_vld", 64'(vld_u), 64'd1);
    check("t2_p0", 64'(p_u[15:0]), 64'hEE0C);
    check("t2_p1", 64'(p_u[31:16]), 64'hEE0C);
    check("t2_model", 64'(exp_u[1]) & 64'hFFFF, 64'hEE0C);

    // Signed extremes: -128 * -128 summed over four lanes
    beat(8'h80, 8'h80, 32'h80808080, 1'b1, 1'b0);
    tick();
    bubbles(2);
    check("t3_s0", 64'(p_s[19:0]), 64'h10000);
    check("t3_s1", 64'(p_s[39:20]), 64'h10000);

    // Bubbles interleaved, one bubble carrying last; three real beats of 4 each
    beat(8'h01, 8'h01, 32'h01010101, 1'b0, 1'b0); tick();
    beat(8'h01, 8'h01, 32'h01010101, 1'b1, 1'b1); tick();
    beat(8'h01, 8'h01, 32'h01010101, 1'b0, 1'b0); tick();
    beat(8'h01, 8'h01, 32'h01010101, 1'b0, 1'b1); tick();
    beat(8'h01, 8'h01, 32'h01010101, 1'b1, 1'b0); tick();
    bubbles(2);
    check("t4_vld", 64'(vld_u), 64'd1);
    check("t4_p0", 64'(p_u[15:0]), 64'd12);

    // Stall five cycles while vld is high, then stall mid-group
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat(8'h55, 8'h33, $urandom, 1'b1, 1'b0);
      tick();
    end
    check("t5_frozen_vld", 64'(vld_u), 64'd1);
    check("t5_frozen_p", 64'(p_u[15:0]), 64'd12);
    en = 1'b1;
    beat(8'h02, 8'h03, 32'h01010101, 1'b0, 1'b0); tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(8'h7F, 8'h7F, $urandom, 1'b1, 1'b0);
      tick();
    end
    en = 1'b1;
    beat(8'h02, 8'h03, 32'h01010101, 1'b1, 1'b0); tick();
    bubbles(2);
    check("t5_p0", 64'(p_u[15:0]), 64'd16);
    check("t5_p1", 64'(p_u[31:16]), 64'd24);

    // Reset after two of four beats, then a fresh one-beat group
    beat(8'h05, 8'h05, 32'h05050505, 1'b0, 1'b0); tick(); tick();
    rst = 1'b1;
    tick();
    check("t6_rst_vld", 64'(vld_u), 64'd0);
    rst = 1'b0;
    beat(8'h01, 8'hFF, 32'h02020202, 1'b1, 1'b0); tick();
    bubbles(2);
    check("t6_p0", 64'(p_u[15:0]), 64'd8);
    check("t6_p1", 64'(p_u[31:16]), 64'hFFF8);

    // Randomised traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 4) != 0);
      zero = ($urandom_range(0, 4) == 0);
      last = ($urandom_range(0, 2) == 0);
      w    = {$urandom, $urandom};
      a    = $urandom;
      tick();
    end
    rst = 1'b0; en = 1'b1;
    bubbles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
